// File: rtl/user_io_pkg.sv
// Shared constants for the user_io_ps2x slice.
//   - SPI command codes decoded by the top level.
//   - Default core type byte returned as byte 0 of every transaction.
//   - PS/2 serializer state encoding.
package user_io_pkg;

  localparam logic [7:0] CMD_BUT_SW   = 8'h01;
  localparam logic [7:0] CMD_JOY0     = 8'h02;
  localparam logic [7:0] CMD_JOY1     = 8'h03;
  localparam logic [7:0] CMD_MOUSE    = 8'h04;
  localparam logic [7:0] CMD_KBD      = 8'h05;
  localparam logic [7:0] CMD_GET_CONF = 8'h14;
  localparam logic [7:0] CMD_STATUS   = 8'h15;

  localparam logic [7:0] CORE_TYPE_8BIT = 8'hA4;

  typedef logic [1:0] ps2_state_t;
  localparam ps2_state_t PS2_IDLE = 2'd0;
  localparam ps2_state_t PS2_BIT  = 2'd1;
  localparam ps2_state_t PS2_GAP  = 2'd2;

endpackage

// File: rtl/ps2_tx_chan.sv
// One buffered PS/2 transmit channel: byte FIFO, 11-bit frame serializer and bit-cell divider.
//   clk, reset     system clock, synchronous active-high reset (flushes FIFO, lines idle high)
//   push, din      write one byte into the FIFO
//   ps2_clk        PS/2 clock line (registered)
//   ps2_data       PS/2 data line (registered)
//   ovf            1-clk pulse when a pushed byte is dropped because the FIFO is full
module ps2_tx_chan
  import user_io_pkg::*;
#(
  parameter int unsigned FIFO_BITS = 3,
  parameter int unsigned DIV       = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] din,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       ovf
);

  localparam int unsigned DEPTH = 1 << FIFO_BITS;
  localparam int unsigned CELL  = 2 * DIV;
  localparam int unsigned CW    = $clog2(CELL);

  logic [7:0]           mem [DEPTH];
  logic [FIFO_BITS-1:0] wr_ptr, rd_ptr;
  logic [FIFO_BITS:0]   count;
  ps2_state_t           state, state_d;
  logic [3:0]           bit_idx, bit_idx_d;
  logic [CW-1:0]        cnt, cnt_d;
  logic [10:0]          frame, frame_d;
  logic                 pop, full, do_push, cell_end, clk_d, data_d;

  assign full     = (count == (FIFO_BITS + 1)'(DEPTH));
  // A pop in the same cycle frees a slot, so a push to a full FIFO is still accepted.
  assign do_push  = push && (!full || pop);
  assign cell_end = (cnt == CW'(CELL - 1));

  // The byte being serialized keeps its FIFO slot until its frame and gap are done,
  // so occupancy counts the in-flight byte as well.
  always_comb begin
    state_d   = state;
    bit_idx_d = bit_idx;
    cnt_d     = cnt;
    frame_d   = frame;
    pop       = 1'b0;
    case (state)
      PS2_IDLE: begin
        if (count != '0) begin
          frame_d   = {1'b1, ~^mem[rd_ptr], mem[rd_ptr], 1'b0};
          state_d   = PS2_BIT;
          bit_idx_d = 4'd0;
          cnt_d     = '0;
        end
      end
      PS2_BIT: begin
        cnt_d = cnt + 1'b1;
        if (cell_end) begin
          cnt_d = '0;
          if (bit_idx == 4'd10) state_d = PS2_GAP;
          else bit_idx_d = bit_idx + 4'd1;
        end
      end
      PS2_GAP: begin
        cnt_d = cnt + 1'b1;
        if (cell_end) begin
          cnt_d   = '0;
          state_d = PS2_IDLE;
          pop     = 1'b1;
        end
      end
      default: state_d = PS2_IDLE;
    endcase
    clk_d  = !((state_d == PS2_BIT) && (cnt_d >= CW'(DIV)));
    data_d = (state_d == PS2_BIT) ? frame_d[bit_idx_d] : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      state    <= PS2_IDLE;
      bit_idx  <= 4'd0;
      cnt      <= '0;
      frame    <= '1;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
      ovf      <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !pop) count <= count + 1'b1;
      else if (!do_push && pop) count <= count - 1'b1;
      state    <= state_d;
      bit_idx  <= bit_idx_d;
      cnt      <= cnt_d;
      frame    <= frame_d;
      ps2_clk  <= clk_d;
      ps2_data <= data_d;
      ovf      <= push && !do_push;
    end
  end

endmodule

// File: rtl/user_io_ps2x.sv
// MiST user_io successor: oversampled SPI slave to the IO controller.
//   clk, reset            system clock (>= 4x spi_sck), synchronous active-high reset
//   spi_sck/ss_io/mosi    asynchronous SPI inputs (mode 0, MSB first)
//   spi_miso, spi_miso_oe SPI data out and pad enable
//   conf_str              config string, first char in the MS byte
//   joy0, joy1, buttons, switches, status   decoded command registers
//   ps2_kbd_*, ps2_mouse_*                  PS/2 transmit lines
//   kbd_ovf, mouse_ovf                      1-clk pulse on dropped PS/2 byte
module user_io_ps2x
  import user_io_pkg::*;
#(
  parameter logic [7:0]  CORE_TYPE     = CORE_TYPE_8BIT,
  parameter int unsigned CONF_LEN      = 16,
  parameter int unsigned JOY_W         = 8,
  parameter int unsigned STATUS_W      = 8,
  parameter int unsigned PS2_FIFO_BITS = 3,
  parameter int unsigned PS2_DIV       = 500
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_sck,
  input  logic                  spi_ss_io,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  input  logic [8*CONF_LEN-1:0] conf_str,
  output logic [JOY_W-1:0]      joy0,
  output logic [JOY_W-1:0]      joy1,
  output logic [1:0]            buttons,
  output logic [1:0]            switches,
  output logic [STATUS_W-1:0]   status,
  output logic                  ps2_kbd_clk,
  output logic                  ps2_kbd_data,
  output logic                  ps2_mouse_clk,
  output logic                  ps2_mouse_data,
  output logic                  kbd_ovf,
  output logic                  mouse_ovf
);

  logic [1:0]          sck_sync, ss_sync, mosi_sync;
  logic                sck_prev, ss_prev, ss, sck_rise, sck_fall, ss_fall;
  logic [2:0]          bit_cnt;
  logic [7:0]          byte_cnt, cmd, rx_byte, tx_byte;
  logic [6:0]          rx_sr, tx_sr;
  logic                byte_done, wr, kbd_push, mouse_push;
  logic [JOY_W-1:0]    joy0_d, joy1_d;
  logic [STATUS_W-1:0] status_d;

  assign ss        = ss_sync[1];
  assign sck_rise  = sck_sync[1] && !sck_prev;
  assign sck_fall  = !sck_sync[1] && sck_prev;
  assign ss_fall   = !ss && ss_prev;
  assign rx_byte   = {rx_sr, mosi_sync[1]};
  assign byte_done = !ss && sck_rise && (bit_cnt == 3'd7);
  // Completed payload byte (index >= 1); byte_cnt still holds its index this cycle.
  assign wr         = byte_done && (byte_cnt != 8'd0);
  assign kbd_push   = wr && (cmd == CMD_KBD);
  assign mouse_push = wr && (cmd == CMD_MOUSE);

  // Byte to shift out next, indexed by the byte about to start.
  always_comb begin
    tx_byte = 8'h00;
    if (byte_cnt == 8'd0) begin
      tx_byte = CORE_TYPE;
    end else if (cmd == CMD_GET_CONF) begin
      for (int unsigned i = 1; i <= CONF_LEN; i++) begin
        if (byte_cnt == 8'(i)) tx_byte = conf_str[8*(CONF_LEN-i) +: 8];
      end
    end
  end

  // Payload byte n lands in bits [8(n-1)+:8]; bits beyond the width are dropped.
  always_comb begin
    joy0_d   = joy0;
    joy1_d   = joy1;
    status_d = status;
    if (wr) begin
      for (int unsigned b = 0; b < JOY_W; b++) begin
        if (byte_cnt == 8'(b / 8 + 1)) begin
          if (cmd == CMD_JOY0) joy0_d[b] = rx_byte[3'(b % 8)];
          if (cmd == CMD_JOY1) joy1_d[b] = rx_byte[3'(b % 8)];
        end
      end
      for (int unsigned b = 0; b < STATUS_W; b++) begin
        if ((byte_cnt == 8'(b / 8 + 1)) && (cmd == CMD_STATUS)) status_d[b] = rx_byte[3'(b % 8)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync    <= 2'b00;
      ss_sync     <= 2'b11;
      mosi_sync   <= 2'b00;
      sck_prev    <= 1'b0;
      ss_prev     <= 1'b1;
      bit_cnt     <= 3'd0;
      byte_cnt    <= 8'd0;
      rx_sr       <= 7'd0;
      tx_sr       <= 7'd0;
      cmd         <= 8'd0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      joy0        <= '0;
      joy1        <= '0;
      status      <= '0;
      buttons     <= 2'b00;
      switches    <= 2'b00;
    end else begin
      sck_sync  <= {sck_sync[0], spi_sck};
      ss_sync   <= {ss_sync[0], spi_ss_io};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      sck_prev  <= sck_sync[1];
      ss_prev   <= ss;
      joy0      <= joy0_d;
      joy1      <= joy1_d;
      status    <= status_d;
      if (ss) begin
        bit_cnt     <= 3'd0;
        byte_cnt    <= 8'd0;
        spi_miso_oe <= 1'b0;
      end else begin
        if (ss_fall) begin
          spi_miso_oe <= 1'b1;
          spi_miso    <= CORE_TYPE[7];
          tx_sr       <= CORE_TYPE[6:0];
        end
        if (sck_rise) begin
          rx_sr   <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
          if (byte_done) begin
            if (byte_cnt == 8'd0) cmd <= rx_byte;
            if (byte_cnt != 8'hFF) byte_cnt <= byte_cnt + 8'd1;
            if (wr && (cmd == CMD_BUT_SW) && (byte_cnt == 8'd1)) begin
              buttons  <= rx_byte[1:0];
              switches <= rx_byte[3:2];
            end
          end
        end
        if (sck_fall) begin
          // bit_cnt wraps to 0 after a full byte: start the next byte's MSB.
          if (bit_cnt == 3'd0) begin
            spi_miso <= tx_byte[7];
            tx_sr    <= tx_byte[6:0];
          end else begin
            spi_miso <= tx_sr[6];
            tx_sr    <= {tx_sr[5:0], 1'b0};
          end
        end
      end
    end
  end

  ps2_tx_chan #(
    .FIFO_BITS(PS2_FIFO_BITS),
    .DIV      (PS2_DIV)
  ) u_kbd (
    .clk     (clk),
    .reset   (reset),
    .push    (kbd_push),
    .din     (rx_byte),
    .ps2_clk (ps2_kbd_clk),
    .ps2_data(ps2_kbd_data),
    .ovf     (kbd_ovf)
  );

  ps2_tx_chan #(
    .FIFO_BITS(PS2_FIFO_BITS),
    .DIV      (PS2_DIV)
  ) u_mouse (
    .clk     (clk),
    .reset   (reset),
    .push    (mouse_push),
    .din     (rx_byte),
    .ps2_clk (ps2_mouse_clk),
    .ps2_data(ps2_mouse_data),
    .ovf     (mouse_ovf)
  );

endmodule
